// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO dequeue controller: FSM encoding and the
// wrap-aware rank eligibility rule.
package pifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_DROP    = 2'd1,
    ST_WAIT_REFRESH = 2'd2
  } deq_state_e;

  localparam int RANK_MAX_WIDTH = 32;

  // A rank is due once virtual time has reached it, compared modulo 2**width:
  // the MSB of (time - rank) is clear when rank lies in the past half-window.
  function automatic logic rank_eligible(
    input logic [RANK_MAX_WIDTH-1:0] time_v,
    input logic [RANK_MAX_WIDTH-1:0] rank_v,
    input int unsigned               width
  );
    logic [RANK_MAX_WIDTH-1:0] diff;
    diff = time_v - rank_v;
    return ~diff[width-1];
  endfunction

endpackage

// File: rtl/pifo_out_fifo.sv
// First-word-fall-through output buffer for dequeued PIFO entries.
module pifo_out_fifo
  import pifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int L2_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    head_data,
  output logic [L2_DEPTH:0]   count,
  output logic                not_empty
);

  localparam int DEPTH = 2**L2_DEPTH;
  localparam logic [L2_DEPTH-1:0] PTR_ONE  = L2_DEPTH'(1);
  localparam logic [L2_DEPTH:0]   CNT_ONE  = (L2_DEPTH+1)'(1);
  localparam logic [L2_DEPTH:0]   CNT_FULL = (L2_DEPTH+1)'(DEPTH);

  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [L2_DEPTH-1:0] wr_ptr_r;
  logic [L2_DEPTH-1:0] rd_ptr_r;
  logic [L2_DEPTH:0]   count_r;
  logic                push_ok_s;
  logic                pop_ok_s;

  // Guard push/pop against overflow and underflow.
  always_comb begin
    push_ok_s = push && (count_r != CNT_FULL);
    pop_ok_s  = pop && (count_r != '0);
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign not_empty = (count_r != '0);

endmodule

// File: rtl/pifo_deq_ctrl.sv
// Pulls the minimum-rank entry out of a PIFO when it is due and there is room,
// paces removes against the PIFO's valid refresh, and buffers results.
module pifo_deq_ctrl
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH   = 8,
  parameter int META_WIDTH   = 8,
  parameter int L2_OUT_DEPTH = 2,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RANK_WIDTH-1:0] pifo_rank,
  input  logic [META_WIDTH-1:0] pifo_meta,
  input  logic                  pifo_valid,
  input  logic                  pifo_empty,
  output logic                  pifo_remove,
  input  logic [RANK_WIDTH-1:0] time_in,
  input  logic                  gate_en,
  output logic [RANK_WIDTH-1:0] m_rank,
  output logic [META_WIDTH-1:0] m_meta,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [31:0]           deq_count,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int OUT_DEPTH = 2**L2_OUT_DEPTH;
  localparam int ENTRY_W   = RANK_WIDTH + META_WIDTH;
  localparam int TMR_W     = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [L2_OUT_DEPTH:0] CNT_FULL = (L2_OUT_DEPTH+1)'(OUT_DEPTH);
  localparam logic [TMR_W-1:0]      TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(WAIT_TIMEOUT - 1);

  deq_state_e          state_r;
  deq_state_e          state_s;
  logic [TMR_W-1:0]    tmr_r;
  logic [31:0]         deq_count_r;
  logic                timeout_err_r;
  logic                rank_ok_s;
  logic                gate_ok_s;
  logic                eligible_s;
  logic                remove_s;
  logic                timeout_hit_s;
  logic                fifo_pop_s;
  logic                fifo_nonempty_s;
  logic [L2_OUT_DEPTH:0] fifo_count_s;
  logic [ENTRY_W-1:0]  fifo_head_s;

  // Eligibility uses the registered FIFO count, keeping m_ready off the remove path.
  always_comb begin
    rank_ok_s = rank_eligible(RANK_MAX_WIDTH'(time_in), RANK_MAX_WIDTH'(pifo_rank),
                              RANK_WIDTH);
    if (gate_en) begin
      gate_ok_s = rank_ok_s;
    end else begin
      gate_ok_s = 1'b1;
    end
    eligible_s = pifo_valid && !pifo_empty && (fifo_count_s < CNT_FULL) && gate_ok_s;
  end

  // Next-state and remove pulse.
  always_comb begin
    state_s       = state_r;
    remove_s      = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (eligible_s && !rst) begin
          remove_s = 1'b1;
          state_s  = ST_WAIT_DROP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_DROP: state_s = ST_WAIT_REFRESH;
      ST_WAIT_REFRESH: begin
        if (pifo_valid || pifo_empty) begin
          state_s = ST_IDLE;
        end else if (tmr_r == TMR_LAST) begin
          timeout_hit_s = 1'b1;
          state_s       = ST_IDLE;
        end else begin
          state_s = ST_WAIT_REFRESH;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counts cycles spent waiting for the PIFO to refresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_r <= '0;
    end else if ((state_r == ST_WAIT_REFRESH) && (state_s == ST_WAIT_REFRESH)) begin
      tmr_r <= tmr_r + TMR_ONE;
    end else begin
      tmr_r <= '0;
    end
  end

  // Dequeue counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      deq_count_r   <= 32'd0;
      timeout_err_r <= 1'b0;
    end else begin
      if (remove_s) begin
        deq_count_r <= deq_count_r + 32'd1;
      end
      if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  pifo_out_fifo #(
    .WIDTH    (ENTRY_W),
    .L2_DEPTH (L2_OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (remove_s),
    .push_data ({pifo_rank, pifo_meta}),
    .pop       (fifo_pop_s),
    .head_data (fifo_head_s),
    .count     (fifo_count_s),
    .not_empty (fifo_nonempty_s)
  );

  // Status is held quiet while reset is applied, not just after it lands.
  assign m_valid     = fifo_nonempty_s && !rst;
  assign fifo_pop_s  = m_valid && m_ready;
  assign m_rank      = fifo_head_s[ENTRY_W-1:META_WIDTH];
  assign m_meta      = fifo_head_s[META_WIDTH-1:0];
  assign pifo_remove = remove_s;
  assign busy        = (state_r != ST_IDLE) && !rst;
  assign timeout_err = timeout_err_r && !rst;
  assign deq_count   = rst ? 32'd0 : deq_count_r;

endmodule

// File: tb/tb_pifo_deq_ctrl.sv
// Directed bench for pifo_deq_ctrl with a small behavioural PIFO model
// (valid drops on the remove edge and returns one cycle later).
module tb_pifo_deq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pifo_rank = 8'd0;
  logic [7:0]  pifo_meta = 8'd0;
  logic        pifo_valid = 1'b0;
  logic        pifo_empty = 1'b1;
  logic        pifo_remove;
  logic [7:0]  time_in = 8'd0;
  logic        gate_en = 1'b0;
  logic [7:0]  m_rank;
  logic [7:0]  m_meta;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] deq_count;
  logic        timeout_err;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pifo_deq_ctrl #(
    .RANK_WIDTH(8), .META_WIDTH(8), .L2_OUT_DEPTH(2), .WAIT_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .pifo_rank(pifo_rank), .pifo_meta(pifo_meta),
    .pifo_valid(pifo_valid), .pifo_empty(pifo_empty), .pifo_remove(pifo_remove),
    .time_in(time_in), .gate_en(gate_en),
    .m_rank(m_rank), .m_meta(m_meta), .m_valid(m_valid), .m_ready(m_ready),
    .deq_count(deq_count), .timeout_err(timeout_err), .busy(busy)
  );

  // PIFO model: bench owns ent_used, model owns ent_gone.
  logic [7:0] ent_rank [16];
  logic [7:0] ent_meta [16];
  bit         ent_used [16];
  bit         ent_gone [16];
  bit         model_stuck = 1'b0;
  int         n_ent = 0;
  int         refresh_left = 0;

  function automatic int min_live();
    int b = -1;
    for (int i = 0; i < 16; i++) begin
      if (ent_used[i] && !ent_gone[i] && (b < 0 || ent_rank[i] < ent_rank[b])) b = i;
    end
    return b;
  endfunction

  always @(posedge clk) begin : pifo_model
    int best;
    if (rst) begin
      for (int i = 0; i < 16; i++) ent_gone[i] = 1'b0;
      refresh_left = 0;
    end else if (pifo_remove) begin
      best = min_live();
      if (best >= 0) ent_gone[best] = 1'b1;
      refresh_left = 1;
    end else if (refresh_left > 0) begin
      refresh_left = refresh_left - 1;
    end
    best = min_live();
    pifo_empty <= (best < 0);
    pifo_valid <= (best >= 0) && (refresh_left == 0) && !model_stuck;
    if (best >= 0) begin
      pifo_rank <= ent_rank[best];
      pifo_meta <= ent_meta[best];
    end
  end

  // Monitor: remove pulses, spacing, protocol, and popped stream.
  int cyc = 0;
  int last_rm = -100;
  int remove_cnt = 0;
  int bad_remove = 0;
  int gap_bad = 0;
  logic [7:0] pop_rank [$];
  logic [7:0] pop_meta [$];

  always @(posedge clk) begin : monitor
    cyc = cyc + 1;
    if (rst) last_rm = -100;
    if (pifo_remove) begin
      if (pifo_valid !== 1'b1 || pifo_empty !== 1'b0) bad_remove = bad_remove + 1;
      if (cyc - last_rm < 3) gap_bad = gap_bad + 1;
      last_rm = cyc;
      remove_cnt = remove_cnt + 1;
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      pop_rank.push_back(m_rank);
      pop_meta.push_back(m_meta);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_ready = 1'b0;
    gate_en = 1'b0;
    time_in = 8'd0;
    model_stuck = 1'b0;
    for (int i = 0; i < 16; i++) ent_used[i] = 1'b0;
    n_ent = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] r);
    ent_rank[n_ent] = r;
    ent_meta[n_ent] = r + 8'h40;
    ent_used[n_ent] = 1'b1;
    n_ent = n_ent + 1;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int i = 0;
    while (pop_rank.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic wait_remove(input int budget, output bit seen);
    int i = 0;
    seen = 1'b0;
    while (!seen && i < budget) begin
      @(negedge clk);
      if (pifo_remove === 1'b1) seen = 1'b1;
      i++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin rst = 1'b0; #1; end
      tests_run++; if (pifo_remove !== 1'b0) begin tests_failed++; $display("FAIL reset_remove ph%0d: got %b want 0", ph, pifo_remove); end
      tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid ph%0d: got %b want 0", ph, m_valid); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy ph%0d: got %b want 0", ph, busy); end
      tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout_err ph%0d: got %b want 0", ph, timeout_err); end
      tests_run++; if (deq_count !== 32'd0) begin tests_failed++; $display("FAIL reset_deq_count ph%0d: got %0d want 0", ph, deq_count); end
    end
  endtask

  task automatic test_order();
    int base_rm, base_pop;
    logic [7:0] exp_r [3];
    exp_r = '{8'd2, 8'd5, 8'd9};
    do_reset();
    m_ready = 1'b1;
    base_rm = remove_cnt;
    base_pop = pop_rank.size();
    load(8'd5); load(8'd2); load(8'd9);
    wait_pops(base_pop + 3, 60);
    repeat (4) @(negedge clk);
    tests_run++; if (pop_rank.size() !== base_pop + 3) begin tests_failed++; $display("FAIL order_pop_count: got %0d want %0d", pop_rank.size() - base_pop, 3); end
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (pop_rank[base_pop + k] !== exp_r[k]) begin tests_failed++; $display("FAIL order_rank[%0d]: got %0d want %0d", k, pop_rank[base_pop + k], exp_r[k]); end
    end
    tests_run++; if (pop_meta[base_pop] !== 8'h42) begin tests_failed++; $display("FAIL order_meta0: got %h want 42", pop_meta[base_pop]); end
    tests_run++; if (remove_cnt - base_rm !== 3) begin tests_failed++; $display("FAIL order_removes: got %0d want 3", remove_cnt - base_rm); end
    tests_run++; if (deq_count !== 32'd3) begin tests_failed++; $display("FAIL order_deq_count: got %0d want 3", deq_count); end
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL order_drained: got m_valid=%b want 0", m_valid); end
  endtask

  task automatic test_gate();
    int base_rm, base_pop;
    do_reset();
    gate_en = 1'b1;
    time_in = 8'd3;
    m_ready = 1'b1;
    base_rm = remove_cnt;
    base_pop = pop_rank.size();
    load(8'd5);
    repeat (10) @(negedge clk);
    tests_run++; if (remove_cnt - base_rm !== 0) begin tests_failed++; $display("FAIL gate_early_removes: got %0d want 0", remove_cnt - base_rm); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL gate_early_busy: got %b want 0", busy); end
    time_in = 8'd5;
    wait_pops(base_pop + 1, 20);
    repeat (3) @(negedge clk);
    tests_run++; if (remove_cnt - base_rm !== 1) begin tests_failed++; $display("FAIL gate_removes: got %0d want 1", remove_cnt - base_rm); end
    tests_run++; if (pop_rank[base_pop] !== 8'd5) begin tests_failed++; $display("FAIL gate_rank: got %0d want 5", pop_rank[base_pop]); end
  endtask

  task automatic test_wrap();
    int base_rm, base_pop;
    do_reset();
    gate_en = 1'b1;
    time_in = 8'h02;
    m_ready = 1'b1;
    base_rm = remove_cnt;
    base_pop = pop_rank.size();
    load(8'hFE);
    wait_pops(base_pop + 1, 20);
    tests_run++; if (pop_rank[base_pop] !== 8'hFE) begin tests_failed++; $display("FAIL wrap_rank: got %h want fe", pop_rank[base_pop]); end
    tests_run++; if (pop_meta[base_pop] !== 8'h3E) begin tests_failed++; $display("FAIL wrap_meta: got %h want 3e", pop_meta[base_pop]); end
    load(8'h04);
    repeat (10) @(negedge clk);
    tests_run++; if (remove_cnt - base_rm !== 1) begin tests_failed++; $display("FAIL wrap_future_blocked: got %0d removes want 1", remove_cnt - base_rm); end
    tests_run++; if (pifo_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_model_valid: got %b want 1", pifo_valid); end
  endtask

  task automatic test_backpressure();
    int base_rm, base_pop;
    logic [7:0] exp_r [6];
    exp_r = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    do_reset();
    base_rm = remove_cnt;
    base_pop = pop_rank.size();
    load(8'd30); load(8'd10); load(8'd50); load(8'd20); load(8'd60); load(8'd40);
    repeat (40) @(negedge clk);
    tests_run++; if (remove_cnt - base_rm !== 4) begin tests_failed++; $display("FAIL bp_removes_full: got %0d want 4", remove_cnt - base_rm); end
    tests_run++; if (deq_count !== 32'd4) begin tests_failed++; $display("FAIL bp_deq_count: got %0d want 4", deq_count); end
    tests_run++; if (m_meta !== 8'h4A) begin tests_failed++; $display("FAIL bp_head_meta: got %h want 4a", m_meta); end
    for (int c = 0; c < 6; c++) begin
      tests_run++; if (m_valid !== 1'b1 || m_rank !== 8'd10) begin tests_failed++; $display("FAIL bp_stable c%0d: got valid=%b rank=%0d want valid=1 rank=10", c, m_valid, m_rank); end
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_pops(base_pop + 6, 80);
    repeat (4) @(negedge clk);
    tests_run++; if (pop_rank.size() !== base_pop + 6) begin tests_failed++; $display("FAIL bp_pop_count: got %0d want 6", pop_rank.size() - base_pop); end
    for (int k = 0; k < 6; k++) begin
      tests_run++; if (pop_rank[base_pop + k] !== exp_r[k]) begin tests_failed++; $display("FAIL bp_rank[%0d]: got %0d want %0d", k, pop_rank[base_pop + k], exp_r[k]); end
    end
    tests_run++; if (remove_cnt - base_rm !== 6) begin tests_failed++; $display("FAIL bp_removes_total: got %0d want 6", remove_cnt - base_rm); end
  endtask

  task automatic test_timeout();
    int base_rm, base_pop;
    bit seen;
    do_reset();
    m_ready = 1'b1;
    base_rm = remove_cnt;
    base_pop = pop_rank.size();
    load(8'd7); load(8'd8);
    wait_remove(20, seen);
    model_stuck = 1'b1;
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL to_first_remove: got seen=%b want 1", seen); end
    repeat (16) @(negedge clk);
    tests_run++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL to_before: got err=%b busy=%b want err=0 busy=1", timeout_err, busy); end
    @(negedge clk);
    tests_run++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL to_fire: got err=%b busy=%b want err=1 busy=0", timeout_err, busy); end
    tests_run++; if (remove_cnt - base_rm !== 1) begin tests_failed++; $display("FAIL to_removes: got %0d want 1", remove_cnt - base_rm); end
    model_stuck = 1'b0;
    wait_pops(base_pop + 2, 30);
    repeat (3) @(negedge clk);
    tests_run++; if (pop_rank[base_pop + 1] !== 8'd8) begin tests_failed++; $display("FAIL to_resume_rank: got %0d want 8", pop_rank[base_pop + 1]); end
    tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    bit seen1, seen2;
    do_reset();
    load(8'd3); load(8'd4); load(8'd5);
    wait_remove(20, seen1);
    wait_remove(20, seen2);
    model_stuck = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b1 || m_valid !== 1'b1 || deq_count !== 32'd2) begin tests_failed++; $display("FAIL rm_pre: got busy=%b m_valid=%b deq=%0d want 1 1 2", busy, m_valid, deq_count); end
    rst = 1'b1;
    #1;
    tests_run++; if (pifo_remove !== 1'b0 || m_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_during: got remove=%b m_valid=%b want 0 0", pifo_remove, m_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_m_valid: got %b want 0", m_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rm_busy: got %b want 0", busy); end
    tests_run++; if (deq_count !== 32'd0) begin tests_failed++; $display("FAIL rm_deq_count: got %0d want 0", deq_count); end
    tests_run++; if (pifo_remove !== 1'b0) begin tests_failed++; $display("FAIL rm_remove: got %b want 0", pifo_remove); end
    model_stuck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_gate();
    test_wrap();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    tests_run++; if (bad_remove !== 0) begin tests_failed++; $display("FAIL remove_protocol: got %0d bad removes want 0", bad_remove); end
    tests_run++; if (gap_bad !== 0) begin tests_failed++; $display("FAIL remove_spacing: got %0d close removes want 0", gap_bad); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pifo_deq_ctrl.md
PIFO_DEQ_CTRL -- requirements
Module: pifo_deq_ctrl

Interface
REQ-001 SHALL have parameter RANK_WIDTH, default 8, rank field width.
REQ-002 SHALL have parameter META_WIDTH, default 8, metadata field width.
REQ-003 SHALL have parameter L2_OUT_DEPTH, default 2, log2 of output FIFO depth; OUT_DEPTH = 2**L2_OUT_DEPTH.
REQ-004 SHALL have parameter WAIT_TIMEOUT, default 15, maximum cycles allowed for a PIFO valid refresh after a remove.
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, reset; reset rst, synchronous, active-high; clock clk.
REQ-006 SHALL have ports: pifo_rank in RANK_WIDTH, current PIFO minimum rank; pifo_meta in META_WIDTH, its metadata; pifo_valid in 1, minimum valid; pifo_empty in 1, PIFO empty flag.
REQ-007 SHALL have port pifo_remove out 1, one-cycle dequeue pulse to PIFO.
REQ-008 SHALL have ports: time_in in RANK_WIDTH, virtual time; gate_en in 1, enable rank-eligibility gating.
REQ-009 SHALL have ports: m_rank out RANK_WIDTH; m_meta out META_WIDTH; m_valid out 1; m_ready in 1; valid/ready output stream.
REQ-010 SHALL have ports: deq_count out 32, dequeued-entry counter; timeout_err out 1, sticky refresh-timeout flag; busy out 1, FSM not in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_DROP, WAIT_REFRESH.
REQ-012 Eligible SHALL mean pifo_valid=1, pifo_empty=0, output FIFO count < OUT_DEPTH, and (gate_en=0 or MSB of (time_in - pifo_rank) mod 2**RANK_WIDTH = 0).
REQ-013 In IDLE and eligible, SHALL assert pifo_remove for exactly that cycle, write {pifo_rank, pifo_meta} into output FIFO on the same edge, go to WAIT_DROP.
REQ-014 WAIT_DROP SHALL last exactly one cycle, pifo_remove=0, then go to WAIT_REFRESH (PIFO clears valid on the remove edge; pifo_valid is ignored in WAIT_DROP).
REQ-015 WAIT_REFRESH SHALL return to IDLE when pifo_valid=1 or pifo_empty=1; no remove issued in this state.
REQ-016 WAIT_REFRESH SHALL count cycles; on reaching WAIT_TIMEOUT without exit, SHALL set timeout_err=1 and return to IDLE.
REQ-017 Back-to-back removes SHALL be separated by at least 3 cycles (IDLE->WAIT_DROP->WAIT_REFRESH->IDLE minimum).
REQ-018 pifo_remove SHALL never assert when pifo_valid=0 or pifo_empty=1.
REQ-019 Output FIFO SHALL be first-word-fall-through, OUT_DEPTH entries, wrap-around read/write pointers of L2_OUT_DEPTH bits plus count of L2_OUT_DEPTH+1 bits.
REQ-020 m_valid SHALL equal (count > 0); m_rank/m_meta SHALL show head entry; pop on m_valid and m_ready.
REQ-021 Simultaneous FIFO push and pop SHALL leave count unchanged; a pop in a cycle with count = OUT_DEPTH SHALL not make that cycle eligible (eligibility uses registered count).
REQ-022 m_rank/m_meta/m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-023 deq_count SHALL increment by 1 per pifo_remove pulse, wrapping modulo 2**32.
REQ-024 timeout_err SHALL clear only on reset.

Reset
REQ-025 On rst=1 at a clk edge, SHALL enter IDLE, clear FIFO pointers and count, timeout counter, deq_count, timeout_err.
REQ-026 During and in the cycle after reset: pifo_remove=0, m_valid=0, busy=0, timeout_err=0, deq_count=0; m_rank/m_meta undefined while m_valid=0.
REQ-027 Reset mid-operation (any state, FIFO non-empty) SHALL discard buffered entries; no remove pulse on the reset edge.

Structure
REQ-028 FSM state encoding and the eligibility compare width rule SHALL live in shared package pifo_pkg.
REQ-029 Output FIFO SHALL be one sub-module, pifo_out_fifo (FWFT, parameterised width and depth).
REQ-030 FSM, timeout counter, deq_count SHALL reside in pifo_deq_ctrl; no combinational path from m_ready to pifo_remove.

Verification
REQ-031 PIFO model holding ranks {5,2,9}, gate_en=0, m_ready=1 -> m_rank sequence 2,5,9; exactly 3 remove pulses, each >=3 cycles apart; deq_count=3.
REQ-032 gate_en=1, time_in=3, min rank 5 -> no remove; time_in steps to 5 -> one remove, m_rank=5.
REQ-033 m_ready=0, OUT_DEPTH=4, 6 entries in PIFO -> exactly 4 removes, m_valid=1 held stable; m_ready=1 -> remaining 2 drained, order preserved.
REQ-034 Model keeps pifo_valid=0 after remove with pifo_empty=0 -> timeout_err=1 after 15 cycles in WAIT_REFRESH, FSM back to IDLE.
REQ-035 gate_en=1, time_in=0x02, rank 0xFE -> eligible (wrap compare); rank 0x04 -> not eligible.
REQ-036 rst asserted in WAIT_REFRESH with 2 buffered entries -> next cycle m_valid=0, busy=0, deq_count=0, pifo_remove=0.
